z80_io_ctrl: RTL and testbench
==============================

Name: z80_io_ctrl

Overview:
- Parametrised pad-side conditioning block between the pad ring and the cpu_z80 core.
- Input path: synchronises the asynchronous pad inputs, edge-detects NMI and produces a stretched, synchronously released core reset.
- Output path: registers all core outputs onto active-low pad strobes and runs a data-bus turnaround FSM that controls DO_OE, with write acknowledge back to the core.
- ADDR_W and DATA_W are parameters, so the address bus is a full ADDR_W bits wide.

Parameters:
ADDR_W, 16, address bus width in bits
DATA_W, 8, data bus width in bits
SYNC_STAGES, 2, flops in each input synchroniser chain (minimum 2)
RST_STRETCH, 4, cycles RESET_CORE stays high after RESET falls (minimum 1)
TURN_CYC, 1, dead cycles with DO_OE low on each bus direction change (0 to 7)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
DI_PAD  in  DATA_W  data in from pads
INT_N_PAD  in  1  interrupt request from pad, active-low
NMI_N_PAD  in  1  non-maskable interrupt from pad, active-low
WAIT_N_PAD  in  1  wait request from pad, active-low
DI_S  out  DATA_W  synchronised data to core
INT_S  out  1  synchronised interrupt level, active-high
NMI_PULSE  out  1  one-cycle pulse on each NMI falling edge
WAIT_S  out  1  synchronised wait level, active-high
RESET_CORE  out  1  stretched core reset, active-high
DO_C  in  DATA_W  write data from core
ADDR_C  in  ADDR_W  address from core
WR_C, MREQ_C, IORQ_C, HALT_C, M1_C  in  1 each  core strobes, active-high
WR_ACK  out  1  write data is being driven (FSM in DRIVE)
DO  out  DATA_W  registered write data to pads
DO_OE  out  1  data pad output enable
ADDR  out  ADDR_W  registered address to pads
WR_N, MREQ_N, IORQ_N, HALT_N, M1_N  out  1 each  registered strobes to pads, active-low

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-high; every flop clears on it.
- Reset values of outputs:
  - DI_S=0, INT_S=0, WAIT_S=0, NMI_PULSE=0.
  - RESET_CORE=1, DO=0, ADDR=0, DO_OE=0, WR_ACK=0.
  - All *_N outputs = 1.
  - Synchroniser chains load their inactive value (pad high for the _N inputs, 0 for DI).
  - FSM state = RD.
- Reset stretch:
  - RESET_CORE asserts asynchronously with RESET.
  - After RESET falls, a counter releases RESET_CORE on the RST_STRETCH-th rising CLK edge.
  - A RESET pulse mid-count restarts the count.
- Input synchronisers:
  - DI_PAD and the three _N inputs each pass through SYNC_STAGES flops.
  - INT_S = ~synced INT_N; WAIT_S = ~synced WAIT_N. Latency is SYNC_STAGES cycles.
- NMI detection:
  - NMI_PULSE is high for exactly one cycle when the synced NMI_N goes 1 to 0, at latency SYNC_STAGES+1.
  - Holding NMI_N low produces no further pulses. A pulse requires NMI_N to return high for at least one synced cycle first.
  - No pulse fires while RESET_CORE=1; the edge detector still tracks the pin during that time.
- Output registers:
  - Every cycle: ADDR<=ADDR_C, DO<=DO_C, MREQ_N<=~MREQ_C, IORQ_N<=~IORQ_C, HALT_N<=~HALT_C, M1_N<=~M1_C. Latency 1 cycle.
  - WR_N<=~(WR_C & next_state==DRIVE), so the write strobe never precedes the data drive.
- Turnaround FSM (states RD, TURN_W, DRIVE, TURN_R); a counter tracks TURN_CYC:
  - RD: DO_OE=0. On WR_C=1, go to TURN_W with counter=0, or straight to DRIVE if TURN_CYC=0.
  - TURN_W: DO_OE=0. Counter increments each cycle; go to DRIVE when it reaches TURN_CYC-1. If WR_C drops, return to RD.
  - DRIVE: DO_OE=1, WR_ACK=1. Stay while WR_C=1. On WR_C=0, go to TURN_R, or to RD if TURN_CYC=0.
  - TURN_R: DO_OE=0. Count TURN_CYC cycles, then RD. If WR_C rises, go to TURN_W with counter reset.
  - DO_OE and WR_ACK are registered outputs of the state.
- RESET_CORE=1 forces the FSM to RD synchronously, and WR_C is ignored while it is high.
- The core must hold WR_C and DO_C until WR_ACK has been seen.

Decomposition:
- Shared package z80_pkg:
  - FSM state typedef (RD, TURN_W, DRIVE, TURN_R).
  - Default widths and constants (ADDR_W_DEF=16, DATA_W_DEF=8).
- One natural sub-module: z80_sync, a parametrised SYNC_STAGES synchroniser with a reset-value parameter. It is instantiated for DI (DATA_W wide) and for each of the three control inputs.

Test Plan:
- Reset release: RESET high 3 cycles then low, RST_STRETCH=4 -> RESET_CORE falls on the 4th rising edge; all *_N=1, DO_OE=0 throughout.
- NMI: NMI_N_PAD low for 20 cycles, then high, then low again -> exactly two single-cycle NMI_PULSEs, each 3 cycles after its falling edge (SYNC_STAGES=2). A low during RESET_CORE gives none.
- Write with TURN_CYC=2: WR_C rises at cycle t with DO_C=0xA5 -> DO_OE=1, WR_ACK=1, WR_N=0 from t+3, DO=0xA5. WR_C drops at t+6 -> DO_OE=0 at t+7; RD after 2 more cycles.
- TURN_CYC=0: back-to-back writes -> DO_OE rises 1 cycle after WR_C with no gaps. Read then write -> no dead cycle.
- Abort and re-arm: WR_C drops during TURN_W -> RD and DO_OE never rises. WR_C rises during TURN_R -> TURN_W with the full TURN_CYC count restarted.
- Width and latency: ADDR_W=16, ADDR_C=0x8001 -> ADDR=0x8001 one cycle later. DI_PAD=0x3C -> DI_S=0x3C after SYNC_STAGES cycles. RESET mid-write -> DO_OE=0 and WR_N=1 immediately, asynchronously.

Source files
------------

// File: rtl/z80_pkg.sv
// Shared types and default widths for the Z80 pad-side I/O conditioning block.
package z80_pkg;
  typedef enum logic [1:0] {
    RD     = 2'd0,
    TURN_W = 2'd1,
    DRIVE  = 2'd2,
    TURN_R = 2'd3
  } turn_state_t;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/z80_sync.sv
// Multi-flop synchroniser; all stages load RST_VAL on reset so the
// output shows the pad's inactive level until real data arrives.
module z80_sync #(
  parameter int             W       = 1,
  parameter int             STAGES  = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] chain [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= RST_VAL;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/z80_io_ctrl.sv
// Pad-side conditioning for cpu_z80: input synchronisers, NMI edge detect,
// stretched core reset, registered pad strobes and data-bus turnaround FSM.
module z80_io_ctrl
  import z80_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int RST_STRETCH = 4,
  parameter int TURN_CYC    = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DI_PAD,
  input  logic              INT_N_PAD,
  input  logic              NMI_N_PAD,
  input  logic              WAIT_N_PAD,
  output logic [DATA_W-1:0] DI_S,
  output logic              INT_S,
  output logic              NMI_PULSE,
  output logic              WAIT_S,
  output logic              RESET_CORE,
  input  logic [DATA_W-1:0] DO_C,
  input  logic [ADDR_W-1:0] ADDR_C,
  input  logic              WR_C,
  input  logic              MREQ_C,
  input  logic              IORQ_C,
  input  logic              HALT_C,
  input  logic              M1_C,
  output logic              WR_ACK,
  output logic [DATA_W-1:0] DO,
  output logic              DO_OE,
  output logic [ADDR_W-1:0] ADDR,
  output logic              WR_N,
  output logic              MREQ_N,
  output logic              IORQ_N,
  output logic              HALT_N,
  output logic              M1_N
);
  localparam int              RST_CW    = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;
  localparam logic [RST_CW-1:0] RST_LOAD = RST_CW'(RST_STRETCH - 1);
  localparam logic [2:0]      TURN_LAST = (TURN_CYC > 0) ? 3'(TURN_CYC - 1) : 3'd0;
  localparam bit              NO_TURN   = (TURN_CYC == 0);

  logic              int_n_s, nmi_n_s, wait_n_s, nmi_n_prev;
  logic [RST_CW-1:0] rst_cnt;
  turn_state_t       state, state_nxt;
  logic [2:0]        turn_cnt, turn_cnt_nxt;

  z80_sync #(.W(DATA_W), .STAGES(SYNC_STAGES), .RST_VAL({DATA_W{1'b0}})) u_sync_di (
    .clk(CLK), .rst(RESET), .d(DI_PAD), .q(DI_S));
  z80_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_int (
    .clk(CLK), .rst(RESET), .d(INT_N_PAD), .q(int_n_s));
  z80_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nmi (
    .clk(CLK), .rst(RESET), .d(NMI_N_PAD), .q(nmi_n_s));
  z80_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_wait (
    .clk(CLK), .rst(RESET), .d(WAIT_N_PAD), .q(wait_n_s));

  assign INT_S  = ~int_n_s;
  assign WAIT_S = ~wait_n_s;

  // Core reset asserts with RESET and releases on the RST_STRETCH-th edge after.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rst_cnt    <= RST_LOAD;
      RESET_CORE <= 1'b1;
    end else if (RESET_CORE) begin
      if (rst_cnt == '0) RESET_CORE <= 1'b0;
      else               rst_cnt    <= rst_cnt - 1'b1;
    end
  end

  // Edge detector keeps tracking during core reset; only the pulse is masked.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      nmi_n_prev <= 1'b1;
      NMI_PULSE  <= 1'b0;
    end else begin
      nmi_n_prev <= nmi_n_s;
      NMI_PULSE  <= nmi_n_prev & ~nmi_n_s & ~RESET_CORE;
    end
  end

  always_comb begin
    state_nxt    = state;
    turn_cnt_nxt = turn_cnt;
    if (RESET_CORE) begin
      state_nxt    = RD;
      turn_cnt_nxt = 3'd0;
    end else begin
      case (state)
        RD: if (WR_C) begin
          if (NO_TURN) state_nxt = DRIVE;
          else         state_nxt = TURN_W;
          turn_cnt_nxt = 3'd0;
        end
        TURN_W: begin
          if (!WR_C)                      state_nxt    = RD;
          else if (turn_cnt == TURN_LAST) state_nxt    = DRIVE;
          else                            turn_cnt_nxt = turn_cnt + 3'd1;
        end
        DRIVE: if (!WR_C) begin
          if (NO_TURN) state_nxt = RD;
          else         state_nxt = TURN_R;
          turn_cnt_nxt = 3'd0;
        end
        TURN_R: begin
          if (WR_C) begin
            state_nxt    = TURN_W;
            turn_cnt_nxt = 3'd0;
          end else if (turn_cnt == TURN_LAST) begin
            state_nxt = RD;
          end else begin
            turn_cnt_nxt = turn_cnt + 3'd1;
          end
        end
        default: state_nxt = RD;
      endcase
    end
  end

  // WR_N follows the next state so the strobe never leads the data drive.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= RD;
      turn_cnt <= 3'd0;
      DO_OE    <= 1'b0;
      WR_ACK   <= 1'b0;
      DO       <= '0;
      ADDR     <= '0;
      WR_N     <= 1'b1;
      MREQ_N   <= 1'b1;
      IORQ_N   <= 1'b1;
      HALT_N   <= 1'b1;
      M1_N     <= 1'b1;
    end else begin
      state    <= state_nxt;
      turn_cnt <= turn_cnt_nxt;
      DO_OE    <= (state_nxt == DRIVE);
      WR_ACK   <= (state_nxt == DRIVE);
      DO       <= DO_C;
      ADDR     <= ADDR_C;
      WR_N     <= ~(WR_C & (state_nxt == DRIVE));
      MREQ_N   <= ~MREQ_C;
      IORQ_N   <= ~IORQ_C;
      HALT_N   <= ~HALT_C;
      M1_N     <= ~M1_C;
    end
  end
endmodule

// File: tb/tb_z80_io_ctrl.sv
// Directed bench for z80_io_ctrl: one instance with TURN_CYC=2, one with TURN_CYC=0.
module tb_z80_io_ctrl;
  import z80_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  DI_PAD;
  logic        INT_N_PAD, NMI_N_PAD, WAIT_N_PAD;
  logic [7:0]  DO_C;
  logic [15:0] ADDR_C;
  logic        WR_C, MREQ_C, IORQ_C, HALT_C, M1_C;

  logic [7:0]  di_s, dout;
  logic        int_s, nmi_pulse, wait_s, reset_core, wr_ack, do_oe;
  logic [15:0] addr;
  logic        wr_n, mreq_n, iorq_n, halt_n, m1_n;

  logic [7:0]  di_s0, dout0;
  logic        int_s0, nmi_pulse0, wait_s0, reset_core0, wr_ack0, do_oe0;
  logic [15:0] addr0;
  logic        wr_n0, mreq_n0, iorq_n0, halt_n0, m1_n0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  z80_io_ctrl #(.ADDR_W(16), .DATA_W(8), .SYNC_STAGES(2), .RST_STRETCH(4), .TURN_CYC(2)) u_dut (
    .CLK(CLK), .RESET(RESET), .DI_PAD(DI_PAD), .INT_N_PAD(INT_N_PAD), .NMI_N_PAD(NMI_N_PAD),
    .WAIT_N_PAD(WAIT_N_PAD), .DI_S(di_s), .INT_S(int_s), .NMI_PULSE(nmi_pulse), .WAIT_S(wait_s),
    .RESET_CORE(reset_core), .DO_C(DO_C), .ADDR_C(ADDR_C), .WR_C(WR_C), .MREQ_C(MREQ_C),
    .IORQ_C(IORQ_C), .HALT_C(HALT_C), .M1_C(M1_C), .WR_ACK(wr_ack), .DO(dout), .DO_OE(do_oe),
    .ADDR(addr), .WR_N(wr_n), .MREQ_N(mreq_n), .IORQ_N(iorq_n), .HALT_N(halt_n), .M1_N(m1_n));

  z80_io_ctrl #(.ADDR_W(16), .DATA_W(8), .SYNC_STAGES(2), .RST_STRETCH(4), .TURN_CYC(0)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .DI_PAD(DI_PAD), .INT_N_PAD(INT_N_PAD), .NMI_N_PAD(NMI_N_PAD),
    .WAIT_N_PAD(WAIT_N_PAD), .DI_S(di_s0), .INT_S(int_s0), .NMI_PULSE(nmi_pulse0), .WAIT_S(wait_s0),
    .RESET_CORE(reset_core0), .DO_C(DO_C), .ADDR_C(ADDR_C), .WR_C(WR_C), .MREQ_C(MREQ_C),
    .IORQ_C(IORQ_C), .HALT_C(HALT_C), .M1_C(M1_C), .WR_ACK(wr_ack0), .DO(dout0), .DO_OE(do_oe0),
    .ADDR(addr0), .WR_N(wr_n0), .MREQ_N(mreq_n0), .IORQ_N(iorq_n0), .HALT_N(halt_n0), .M1_N(m1_n0));

  typedef struct {
    logic [15:0] addr_c;
    logic [7:0]  do_c;
    logic [3:0]  strb;       // {MREQ_C, IORQ_C, HALT_C, M1_C}
    logic [15:0] exp_addr;
    logic [7:0]  exp_do;
    logic [3:0]  exp_strb_n; // {MREQ_N, IORQ_N, HALT_N, M1_N}
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int npulse, first;

    vecs[0] = '{16'h8001, 8'h5A, 4'b1010, 16'h8001, 8'h5A, 4'b0101};
    vecs[1] = '{16'hFFFF, 8'hFF, 4'b1111, 16'hFFFF, 8'hFF, 4'b0000};
    vecs[2] = '{16'h0000, 8'h00, 4'b0000, 16'h0000, 8'h00, 4'b1111};
    vecs[3] = '{16'h1234, 8'hC3, 4'b0101, 16'h1234, 8'hC3, 4'b1010};

    RESET = 1'b0; DI_PAD = 8'h00; INT_N_PAD = 1'b1; NMI_N_PAD = 1'b1; WAIT_N_PAD = 1'b1;
    DO_C = 8'h00; ADDR_C = 16'h0000; WR_C = 1'b0;
    MREQ_C = 1'b0; IORQ_C = 1'b0; HALT_C = 1'b0; M1_C = 1'b0;

    // Reset values and stretched release; an NMI low during core reset must not pulse.
    #2 RESET = 1'b1;
    #1;
    chk("rst_reset_core", reset_core, 1);
    chk("rst_pad_n", {wr_n, mreq_n, iorq_n, halt_n, m1_n}, 5'b11111);
    chk("rst_oe_ack", {do_oe, wr_ack, nmi_pulse}, 3'b000);
    chk("rst_addr_do", {addr, dout}, 24'h000000);
    chk("rst_sync", {di_s, int_s, wait_s}, 10'h000);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    NMI_N_PAD = 1'b0;
    npulse = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (nmi_pulse) npulse++;
      if (k <= 5) begin
        chk("rst_stretch", reset_core, (k < 4));
        chk("rst_idle_out", {wr_n, mreq_n, iorq_n, halt_n, m1_n, do_oe}, 6'b111110);
      end
    end
    chk("nmi_in_reset", npulse, 0);
    NMI_N_PAD = 1'b1;
    repeat (4) @(negedge CLK);

    // Output register path, one cycle latency.
    for (int i = 0; i < 4; i++) begin
      ADDR_C = vecs[i].addr_c;
      DO_C   = vecs[i].do_c;
      {MREQ_C, IORQ_C, HALT_C, M1_C} = vecs[i].strb;
      @(negedge CLK);
      chk("vec_addr", addr, vecs[i].exp_addr);
      chk("vec_do", dout, vecs[i].exp_do);
      chk("vec_strb_n", {mreq_n, iorq_n, halt_n, m1_n}, vecs[i].exp_strb_n);
    end
    {MREQ_C, IORQ_C, HALT_C, M1_C} = 4'b0000;

    // Input synchroniser latency of two cycles.
    DI_PAD = 8'h3C; INT_N_PAD = 1'b0; WAIT_N_PAD = 1'b0;
    @(negedge CLK);
    chk("sync_lat1", {di_s, int_s, wait_s}, {8'h00, 2'b00});
    @(negedge CLK);
    chk("sync_lat2", {di_s, int_s, wait_s}, {8'h3C, 2'b11});
    INT_N_PAD = 1'b1; WAIT_N_PAD = 1'b1;
    repeat (3) @(negedge CLK);

    // NMI: two separate falling edges, each one pulse three cycles later.
    NMI_N_PAD = 1'b0; npulse = 0; first = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (nmi_pulse) begin npulse++; if (first == 0) first = k; end
    end
    chk("nmi1_count", npulse, 1);
    chk("nmi1_lat", first, 3);
    NMI_N_PAD = 1'b1; npulse = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      if (nmi_pulse) npulse++;
    end
    chk("nmi_rise_count", npulse, 0);
    NMI_N_PAD = 1'b0; npulse = 0; first = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (nmi_pulse) begin npulse++; if (first == 0) first = k; end
    end
    chk("nmi2_count", npulse, 1);
    chk("nmi2_lat", first, 3);
    NMI_N_PAD = 1'b1;
    repeat (4) @(negedge CLK);

    // Write with TURN_CYC=2: two dead cycles each way.
    WR_C = 1'b1; DO_C = 8'hA5;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      chk("wr_oe", do_oe, (k >= 3));
      chk("wr_ack", wr_ack, (k >= 3));
      chk("wr_n", wr_n, (k < 3));
      chk("wr_do", dout, 8'hA5);
    end
    WR_C = 1'b0;
    @(negedge CLK);
    chk("wr_end_oe_n", {do_oe, wr_ack, wr_n}, 3'b001);
    chk("wr_turn_r1", u_dut.state, TURN_R);
    @(negedge CLK);
    chk("wr_turn_r2", u_dut.state, TURN_R);
    @(negedge CLK);
    chk("wr_back_rd", u_dut.state, RD);
    repeat (2) @(negedge CLK);

    // Abort: WR_C drops during TURN_W, bus is never driven.
    WR_C = 1'b1;
    @(negedge CLK);
    chk("abort_turn_w", u_dut.state, TURN_W);
    WR_C = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      chk("abort_oe", {do_oe, wr_n}, 2'b01);
      if (k == 1) chk("abort_rd", u_dut.state, RD);
    end

    // Re-arm on the last TURN_R cycle restarts the full turnaround count.
    WR_C = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rearm_drive", do_oe, 1);
    WR_C = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rearm_turn_r", u_dut.state, TURN_R);
    WR_C = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      chk("rearm_oe", do_oe, (k == 3));
    end
    WR_C = 1'b0;
    repeat (4) @(negedge CLK);

    // TURN_CYC=0: no dead cycles, back-to-back and read-to-write.
    WR_C = 1'b1; DO_C = 8'h11;
    @(negedge CLK);
    chk("t0_oe1", {do_oe0, wr_ack0, wr_n0}, 3'b110);
    chk("t0_do1", dout0, 8'h11);
    DO_C = 8'h22;
    @(negedge CLK);
    chk("t0_oe2", {do_oe0, wr_n0}, 2'b10);
    chk("t0_do2", dout0, 8'h22);
    WR_C = 1'b0;
    @(negedge CLK);
    chk("t0_rd", {do_oe0, wr_n0}, 2'b01);
    chk("t0_rd_state", u_dut0.state, RD);
    WR_C = 1'b1; DO_C = 8'h33;
    @(negedge CLK);
    chk("t0_oe3", {do_oe0, wr_n0}, 2'b10);
    chk("t0_do3", dout0, 8'h33);
    WR_C = 1'b0;
    repeat (4) @(negedge CLK);

    // Asynchronous RESET in the middle of a drive.
    WR_C = 1'b1; DO_C = 8'h77;
    repeat (3) @(negedge CLK);
    chk("mid_drive", do_oe, 1);
    #1 RESET = 1'b1;
    #1;
    chk("mid_rst_async", {do_oe, wr_ack, wr_n, reset_core}, 4'b0011);
    WR_C = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    repeat (6) @(negedge CLK);
    chk("mid_rst_release", {reset_core, do_oe, wr_n}, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
